// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential divider.
// Optional signed mode is enabled by defining DIV32_SIGNED_EN.
package div32_pkg;

  localparam int DIV_N = 32;
  localparam int DIV_CW = $clog2(DIV_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FIX
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/div32_seq_if.sv
// Operand/result handshake bundle for div32_seq.
// op_signed exists only when DIV32_SIGNED_EN is defined.
interface div32_seq_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
`ifdef DIV32_SIGNED_EN
  logic         op_signed;

  modport master (
    output in_valid, dividend, divisor,
    output out_ready, op_signed,
    input  in_ready, out_valid,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor,
    input  out_ready, op_signed,
    output in_ready, out_valid,
    output quotient, remainder, div_by_zero
  );
`else
  modport master (
    output in_valid, dividend, divisor,
    output out_ready,
    input  in_ready, out_valid,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor,
    input  out_ready,
    output in_ready, out_valid,
    output quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/adder_n.sv
// Ripple-style N-bit adder with carry in/out.
// Shared by the ALU add path and the divider's trial subtract.
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
  assign sum   = full[N-1:0];
  assign c_out = full[N];

endmodule

// File: rtl/div_step.sv
// One restoring-division step on {rem,quo}.
// Trial subtract is a + ~b + 1 through adder_n.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_nxt,
  output logic [N-1:0] quo_nxt
);

  logic [N:0] sh_rem;
  logic [N:0] diff;
  logic       no_borrow;
  logic       take;

  assign sh_rem = {rem, quo[N-1]};

  adder_n #(.N(N + 1)) u_sub (
    .a     (sh_rem),
    .b     (~{1'b0, divisor}),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (no_borrow)
  );

  // accept the trial subtract only if it fits the N-bit remainder
  assign take    = no_borrow & ~diff[N];
  assign rem_nxt = take ? diff[N-1:0] : sh_rem[N-1:0];
  assign quo_nxt = {quo[N-2:0], take};

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Define DIV32_SIGNED_EN for two's-complement mode (adds S_FIX).
module div32_seq
  import div32_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic       clk,
  input  logic       rst,
  div32_seq_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          dbz_q, dbz_d;
  logic [N-1:0]  step_rem, step_quo;
  logic [N-1:0]  dd_mag, dv_mag;

`ifdef DIV32_SIGNED_EN
  logic sgn_q, sgn_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic dd_neg, dv_neg;

  assign dd_neg = bus.op_signed & bus.dividend[N-1];
  assign dv_neg = bus.op_signed & bus.divisor[N-1];
  assign dd_mag = dd_neg ? -bus.dividend : bus.dividend;
  assign dv_mag = dv_neg ? -bus.divisor : bus.divisor;
`else
  assign dd_mag = bus.dividend;
  assign dv_mag = bus.divisor;
`endif

  div_step #(.N(N)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
`ifdef DIV32_SIGNED_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dbz_d = 1'b0;
`ifdef DIV32_SIGNED_EN
          sgn_d  = bus.op_signed;
          qneg_d = dd_neg ^ dv_neg;
          rneg_d = dd_neg;
`endif
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            quo_d   = dd_mag;
            dvs_d   = dv_mag;
            cnt_d   = CW'(N - 1);
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef DIV32_SIGNED_EN
          state_d = sgn_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef DIV32_SIGNED_EN
      S_FIX: begin
        quo_d   = qneg_q ? -quo_q : quo_q;
        rem_d   = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV32_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
`ifdef DIV32_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: handshake, latency, edge cases.
// Signed vectors run only when DIV32_SIGNED_EN is defined.
module tb_div32_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;

  div32_seq_if #(.N(32)) bus ();

  div32_seq #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // drive at negedge, accept on the next posedge
  task automatic start(input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // called at the negedge after the accepting edge
  task automatic wait_done(output int l);
    l = 1;
    while (!bus.out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int exp_lat,
                     input logic [31:0] q,
                     input logic [31:0] r,
                     input logic z);
    start(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"}, bus.quotient, q);
    chk({tag, "_r"}, bus.remainder, r);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(z));
    take();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
`ifdef DIV32_SIGNED_EN
    bus.op_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

    run("d100_7", 32'd100, 32'd7, 33,
        32'd14, 32'd2, 1'b0);
    run("ffff_1", 32'hFFFF_FFFF, 32'd1, 33,
        32'hFFFF_FFFF, 32'd0, 1'b0);
    run("d5_9", 32'd5, 32'd9, 33,
        32'd0, 32'd5, 1'b0);
    run("d0_13", 32'd0, 32'd13, 33,
        32'd0, 32'd0, 1'b0);
    run("dbz", 32'd1234, 32'd0, 1,
        32'hFFFF_FFFF, 32'd1234, 1'b1);
    run("beef_17", 32'hDEAD_BEEF, 32'd17, 33,
        32'd219760503, 32'd8, 1'b0);
    chk("post_take_rdy", 32'(bus.in_ready), 32'd1);

    // stall the consumer while upstream holds the next job
    start(32'd1000, 32'd3);
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd33);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    for (int i = 0; i < 10; i++) begin
      chk("hold_q", bus.quotient, 32'd333);
      chk("hold_r", bus.remainder, 32'd1);
      chk("hold_in_rdy", 32'(bus.in_ready), 32'd0);
      chk("hold_ov", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rel_in_rdy", 32'(bus.in_ready), 32'd1);
    chk("rel_ov", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_q", bus.quotient, 32'd3);
    chk("b2b_r", bus.remainder, 32'd0);
    take();

    // reset in the middle of a run
    start(32'hDEAD_BEEF, 32'd17);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_q", bus.quotient, 32'd0);
    chk("mid_rst_r", bus.remainder, 32'd0);
    chk("mid_rst_dbz", 32'(bus.div_by_zero), 32'd0);
    run("d50_5", 32'd50, 32'd5, 33,
        32'd10, 32'd0, 1'b0);

`ifdef DIV32_SIGNED_EN
    run("uns_fff9_2", 32'hFFFF_FFF9, 32'd2, 33,
        32'h7FFF_FFFC, 32'd1, 1'b0);
    bus.op_signed = 1'b1;
    run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 34,
        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34,
        32'h8000_0000, 32'd0, 1'b0);
    run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 34,
        32'hFFFF_FFFD, 32'd1, 1'b0);
    run("s_dbz", 32'hFFFF_FFFB, 32'd0, 1,
        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    bus.op_signed = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
